// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store funct3
// encodings, FSM state type, and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_WR0,
    S_WR1,
    S_RESP
  } lsu_state_t;

  // Access size in bytes (1, 2 or 4) from funct3[1:0].
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Stores only have signed-width encodings; loads add the unsigned ones.
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   off, size, funct3 : decoded access shape
//   wdata             : store data, LSB-aligned
//   w0, w1            : words at a0 and a0+4
//   wr0_word/wr1_word : w0/w1 with the store bytes merged in
//   load_data         : extracted and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  output logic [31:0] wr0_word,
  output logic [31:0] wr1_word,
  output logic [31:0] load_data
);

  logic [4:0]  sh;
  logic [31:0] size_mask;
  logic [63:0] lane_mask;
  logic [63:0] data64;
  logic [63:0] merged;
  logic [31:0] shifted;

  // Both words are treated as one 64-bit window so a spanning access is
  // just a shift; bytes past the window top fall off harmlessly.
  always_comb begin
    sh = {off, 3'b000};
    case (size)
      3'd1:    size_mask = 32'h0000_00FF;
      3'd2:    size_mask = 32'h0000_FFFF;
      default: size_mask = '1;
    endcase
    lane_mask = {32'b0, size_mask} << sh;
    data64    = {32'b0, wdata} << sh;
    merged    = ({w1, w0} & ~lane_mask) | (data64 & lane_mask);
    wr0_word  = merged[31:0];
    wr1_word  = merged[63:32];
  end

  always_comb begin
    shifted = 32'({w1, w0} >> sh);
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {24'b0, shifted[7:0]};
      F3_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory.
// Splits byte/half/word accesses at any address into aligned word reads
// and writes (read-modify-write for partial stores).
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : request handshake and payload
//   rsp_valid/rdata/err : one-cycle completion pulse and result
//   mem_*               : data_memory interface (word transfers only)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [31:0]       mem_WriteData,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_ReadData
);

  lsu_state_t        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       w0_q;
  logic [31:0]       w1_q;

  logic [1:0]        off_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic              span;

  logic [2:0]        req_size;
  logic              req_err;
  logic [ADDR_W-1:0] req_a0;

  logic [31:0]       w0_src;
  logic [31:0]       w1_src;
  logic [31:0]       wr0_word;
  logic [31:0]       wr1_word;
  logic [31:0]       load_data;

  assign req_ready  = (state == S_IDLE) && !rst;
  assign mem_funct3 = F3_W;

  assign off_q  = addr_q[1:0];
  assign size_q = size_of(f3_q);
  assign a0     = {addr_q[ADDR_W-1:2], 2'b00};
  assign a1     = a0 + ADDR_W'(4);
  assign span   = ({1'b0, off_q} + size_q) > 3'd4;

  // Range check is one bit wider than the address so it cannot wrap.
  assign req_size = size_of(req_funct3);
  assign req_a0   = {req_addr[ADDR_W-1:2], 2'b00};
  assign req_err  = !is_legal(req_we, req_funct3) ||
                    (({1'b0, req_addr} + (ADDR_W+1)'(req_size)) >
                     (ADDR_W+1)'(MEM_BYTES));

  // Outputs are registered, so the word being captured this edge feeds the
  // merge/extract directly instead of waiting a cycle for w0_q/w1_q.
  assign w0_src = (state == S_RD0) ? mem_ReadData : w0_q;
  assign w1_src = (state == S_RD1) ? mem_ReadData : w1_q;

  lsu_align u_align (
    .off       (off_q),
    .size      (size_q),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .w0        (w0_src),
    .w1        (w1_src),
    .wr0_word  (wr0_word),
    .wr1_word  (wr1_word),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      f3_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      w0_q          <= '0;
      w1_q          <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_MemRead   <= 1'b0;
      mem_MemWrite  <= 1'b0;
      mem_Address   <= '0;
      mem_WriteData <= '0;
    end else begin
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      rsp_valid    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_err) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && req_funct3 == F3_W && req_addr[1:0] == 2'b00) begin
              // Full aligned word store: nothing to merge, skip the read.
              state         <= S_WR0;
              mem_MemWrite  <= 1'b1;
              mem_Address   <= req_a0;
              mem_WriteData <= req_wdata;
            end else begin
              state       <= S_RD0;
              mem_MemRead <= 1'b1;
              mem_Address <= req_a0;
            end
          end
        end
        S_RD0: begin
          w0_q <= mem_ReadData;
          if (span) begin
            state       <= S_RD1;
            mem_MemRead <= 1'b1;
            mem_Address <= a1;
          end else if (we_q) begin
            state         <= S_WR0;
            mem_MemWrite  <= 1'b1;
            mem_Address   <= a0;
            mem_WriteData <= wr0_word;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_data;
          end
        end
        S_RD1: begin
          w1_q <= mem_ReadData;
          if (we_q) begin
            state         <= S_WR0;
            mem_MemWrite  <= 1'b1;
            mem_Address   <= a0;
            mem_WriteData <= wr0_word;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_data;
          end
        end
        S_WR0: begin
          if (span) begin
            state         <= S_WR1;
            mem_MemWrite  <= 1'b1;
            mem_Address   <= a1;
            mem_WriteData <= wr1_word;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        S_WR1: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        S_RESP: begin
          state     <= S_IDLE;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests compared against a byte-array memory model.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_MemRead;
  logic              mem_MemWrite;
  logic [ADDR_W-1:0] mem_Address;
  logic [31:0]       mem_WriteData;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_ReadData;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_MemRead   (mem_MemRead),
    .mem_MemWrite  (mem_MemWrite),
    .mem_Address   (mem_Address),
    .mem_WriteData (mem_WriteData),
    .mem_funct3    (mem_funct3),
    .mem_ReadData  (mem_ReadData)
  );

  // data_memory stand-in: combinational read, write on the clock edge.
  logic [31:0] mem [0:MEM_BYTES/4-1];
  assign mem_ReadData = mem[mem_Address[11:2]];
  always @(posedge clk) if (mem_MemWrite) mem[mem_Address[11:2]] <= mem_WriteData;

  // Reference memory, one entry per byte.
  logic [7:0] refm [0:MEM_BYTES-1];

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Strobe monitor
  int unsigned n_rd, n_wr, bad;
  logic [31:0] seq;
  logic [31:0] addr_log [$];
  initial begin n_rd = 0; n_wr = 0; bad = 0; seq = '0; end
  always @(posedge clk) begin
    if (mem_MemRead && mem_MemWrite) bad++;
    if ((mem_MemRead || mem_MemWrite) && mem_Address[1:0] != 2'b00) bad++;
    if (mem_MemRead) begin
      n_rd++; seq = {seq[29:0], 2'b01}; addr_log.push_back(mem_Address);
    end
    if (mem_MemWrite) begin
      n_wr++; seq = {seq[29:0], 2'b10}; addr_log.push_back(mem_Address);
    end
  end

  task automatic set_word(input int unsigned a, input logic [31:0] v);
    mem[a >> 2] = v;
    for (int k = 0; k < 4; k++) refm[(a & ~3) + k] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int unsigned a);
    return {refm[a+3], refm[a+2], refm[a+1], refm[a]};
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int unsigned lat);
    int unsigned w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n_rd = 0; n_wr = 0; seq = '0; addr_log.delete();
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    if (!rsp_valid) chk("ready_busy", 32'(req_ready), 32'd0);
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  // Runs one request and checks it against the reference model.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata);
    int unsigned size, off, lat, e_lat, e_rd, e_wr;
    logic span, legal, e_err, err;
    logic [31:0] e_rdata, rdata, ext;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = addr & 3;
    span  = (off + size) > 4;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    e_err = !legal || (64'(addr) + 64'(size) > 64'(MEM_BYTES));
    e_rdata = '0;
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!we) begin
      e_lat = span ? 3 : 2; e_rd = span ? 2 : 1; e_wr = 0;
      for (int k = 0; k < int'(size); k++) e_rdata[8*k +: 8] = refm[addr + k];
      if (!f3[2] && size < 4 && e_rdata[8*size-1]) begin
        ext = '1;
        e_rdata = e_rdata | (ext << (8*size));
      end
    end else if (f3 == 3'b010 && off == 0) begin
      e_lat = 2; e_rd = 0; e_wr = 1;
    end else begin
      e_lat = span ? 5 : 3; e_rd = span ? 2 : 1; e_wr = span ? 2 : 1;
    end
    run_req(we, f3, addr, wdata, rdata, err, lat);
    chk("err", 32'(err), 32'(e_err));
    chk("rdata", rdata, e_rdata);
    chk("latency", lat, e_lat);
    chk("reads", n_rd, e_rd);
    chk("writes", n_wr, e_wr);
    if (we && !e_err) begin
      for (int k = 0; k < int'(size); k++) refm[addr + k] = wdata[8*k +: 8];
      chk("mem_w0", mem[addr >> 2], ref_word(addr & ~3));
      if (span) chk("mem_w1", mem[(addr >> 2) + 1], ref_word((addr & ~3) + 4));
    end
  endtask

  initial begin
    int unsigned w, seen_rsp;
    logic [31:0] a;
    logic [2:0]  f3s [8];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b000, 3'b010};
    for (int i = 0; i < int'(MEM_BYTES/4); i++) set_word(i*4, $urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_memread", 32'(mem_MemRead), 32'd0);
    chk("rst_memwrite", 32'(mem_MemWrite), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", mem_Address, 32'd0);
    chk("rst_wdata", mem_WriteData, 32'd0);
    chk("mem_funct3", 32'(mem_funct3), 32'd2);
    @(negedge clk); rst = 1'b0; #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Aligned and sub-word loads
    set_word(32'h100, 32'h8899AABB);
    txn(1'b0, 3'b010, 32'h100, '0);
    chk("lw_addr", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD, 32'h100);
    txn(1'b0, 3'b000, 32'h101, '0);
    txn(1'b0, 3'b100, 32'h101, '0);
    txn(1'b0, 3'b001, 32'h102, '0);
    txn(1'b0, 3'b101, 32'h102, '0);

    // Misaligned word load across two words
    set_word(32'h200, 32'h44332211);
    set_word(32'h204, 32'h88776655);
    txn(1'b0, 3'b010, 32'h203, '0);
    chk("lw_span_a0", addr_log.size() > 1 ? addr_log[0] : 32'hDEAD, 32'h200);
    chk("lw_span_a1", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD, 32'h204);

    // Spanning halfword store
    txn(1'b1, 3'b001, 32'h203, 32'h0000BEEF);
    chk("sh_seq", seq, 32'h5A);
    chk("sh_word0", mem[32'h200 >> 2], 32'hEF332211);
    chk("sh_word1", mem[32'h204 >> 2], 32'h887766BE);

    // Error cases
    txn(1'b0, 3'b010, 32'hFFD, '0);
    txn(1'b0, 3'b011, 32'h100, '0);
    txn(1'b1, 3'b100, 32'h100, 32'h12345678);
    txn(1'b1, 3'b010, 32'h100, 32'hCAFEF00D);
    txn(1'b0, 3'b010, 32'hFFC, '0);

    // Reset during WR0 of a spanning store
    set_word(32'h200, 32'h44332211);
    set_word(32'h204, 32'h88776655);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h203; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!mem_MemWrite && w < 20) begin @(posedge clk); #1; w++; end
    chk("rst_wr0_seen", 32'(mem_MemWrite), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_write", 32'(mem_MemWrite), 32'd0);
    chk("rst_mid_read", 32'(mem_MemRead), 32'd0);
    @(negedge clk); rst = 1'b0;
    n_rd = 0; n_wr = 0; seen_rsp = 0;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (8) begin @(posedge clk); #1; if (rsp_valid) seen_rsp++; end
    chk("rst_mid_no_rsp", seen_rsp, 32'd0);
    chk("rst_mid_no_strobe", n_rd + n_wr, 32'd0);
    chk("rst_mid_w0", mem[32'h200 >> 2], 32'hEF332211);
    chk("rst_mid_w1", mem[32'h204 >> 2], 32'h88776655);
    refm[32'h203] = 8'hEF;

    // Random requests
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom_range(4080, 4100);
      else a = $urandom_range(0, 255);
      txn(1'($urandom_range(0, 1)), f3s[$urandom_range(0, 7)], a, $urandom);
    end

    chk("strobe_rules", bad, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the execute stage and data_memory, which supports only aligned 32-bit word transfers (funct3=010). Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) at any byte address over a valid/ready handshake. Splits each request into aligned word reads and writes, doing read-modify-write for sub-word and misaligned stores. Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
MEM_BYTES, 4096, data_memory size in bytes; accesses past it are errors
ADDR_W, 32, width of request and memory address

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept; high only in IDLE and rst low
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid; illegal funct3 or out of range
mem_MemRead  out  1  to data_memory MemRead
mem_MemWrite  out  1  to data_memory MemWrite
mem_Address  out  ADDR_W  word-aligned address; low 2 bits always 0
mem_WriteData  out  32  merged word to write
mem_funct3  out  3  constant 3'b010
mem_ReadData  in  32  combinational read data from data_memory

Behaviour:
- Reset: state IDLE. req_ready, rsp_valid, rsp_err, mem_MemRead and mem_MemWrite are 0. rsp_rdata, mem_Address and mem_WriteData are 0. Latched request is cleared.
- Accept on the rising edge where req_valid && req_ready. The block latches we, funct3, addr and wdata.
- Derived values: off = addr[1:0]; size = 1, 2 or 4 from funct3[1:0]; a0 = addr & ~3; a1 = a0 + 4; span = (off + size > 4).
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Error checks:
  - Illegal funct3 is an error.
  - addr + size > MEM_BYTES is an error, computed at ADDR_W+1 bits so it cannot wrap.
  - On error: IDLE -> RESP with rsp_err=1 and no memory strobe.
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
  - RD0: MemRead=1, Address=a0; capture w0 = mem_ReadData at the edge.
  - RD1: MemRead=1, Address=a1; capture w1.
  - WR0: MemWrite=1, Address=a0, WriteData = w0 with bytes [off .. min(off+size,4)-1] replaced by low bytes of wdata.
  - WR1: MemWrite=1, Address=a1, WriteData = w1 with bytes [0 .. off+size-5] replaced by the remaining wdata bytes.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Transitions:
  - Load: RD0 -> (span ? RD1 : RESP); RD1 -> RESP.
  - Store with funct3=010 and off=0: IDLE -> WR0 -> RESP, skipping the read.
  - Other stores: RD0 -> [RD1 if span] -> WR0 -> [WR1 if span] -> RESP.
- Latency from the accept edge to the rsp_valid cycle:
  - Aligned load: 2 cycles.
  - Aligned SW: 2 cycles.
  - Misaligned load: 3 cycles.
  - Sub-word store, no span: 3 cycles.
  - Spanning store: 5 cycles.
  - Error: 1 cycle.
- Load data: {w1,w0} >> (8*off), then low size bytes are sign-extended (000, 001) or zero-extended (100, 101). LW returns 32 bits unchanged.
- Only one request is in flight at a time. req_valid while busy is ignored, not queued, and the requester holds it.
- Only one memory strobe is active per cycle. MemRead and MemWrite are never high together.
- Reset mid-operation:
  - A WR cycle coinciding with the reset edge still commits in data_memory, which has no reset. No later strobe is issued.
  - A spanning store interrupted between WR0 and WR1 leaves memory torn. This is accepted.
  - No rsp_valid follows the reset.

Decomposition:
- lsu_pkg holds funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the state enum encoding, and a size-from-funct3 function.
- One sub-module, lsu_align, is purely combinational. It holds the byte-lane merge for WR0/WR1 and the load extract/extend. The FSM and latches stay in load_store_unit.

Test Plan:
- Preload word 0x100 = 0x8899AABB; LW 0x100 -> rsp_valid 2 cycles after accept, rdata=0x8899AABB, exactly one MemRead.
- Same preload; LB 0x101 -> 0xFFFFFFAA; LBU 0x101 -> 0x000000AA; LH 0x102 -> 0xFFFF8899; LHU 0x102 -> 0x00008899.
- Word 0x200 = 0x44332211, 0x204 = 0x88776655; LW 0x203 -> 0x77665544, two reads at 0x200 and 0x204, latency 3.
- Same words; SH 0x203, wdata=0xBEEF -> 0x200 = 0xEF332211, 0x204 = 0x887766BE, strobe sequence R,R,W,W, latency 5.
- LW 0xFFD with MEM_BYTES=4096 -> rsp_err=1, rdata=0, no strobes. Load funct3=011 -> rsp_err=1. Store funct3=100 -> rsp_err=1.
- Assert rst during WR0 of the spanning SH above -> WR0 word updated, 0x204 unchanged, no rsp_valid, req_ready=1 the cycle after rst falls.
